gcl_sequencer: RTL

//  Time-aware gate control (802.1Qbv-style) sequencer for the 8 traffic-class queues of the traffic generator.

---
 rtl/gcl_sequencer_pkg.sv | 20 ++
 rtl/gcl_ram.sv | 34 +++
 rtl/gcl_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gcl_sequencer_pkg.sv
// rtl/gcl_sequencer_pkg.sv - shared constants for the gate control list sequencer
package gcl_sequencer_pkg;

    // Width of the per-queue gate mask (one bit per traffic class)
    localparam int GCL_MASK_W = 8;

    // Entry layout: {gate_mask, duration}; duration occupies the low bits,
    // the mask sits directly above it at bit offset DUR_W.
    localparam int GCL_DUR_LSB = 0;

    // Shortest duration an entry may be held; shorter programmed values are
    // stretched so the next entry's prefetched read always completes in time.
    localparam int GCL_MIN_DUR = 2;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/gcl_ram.sv
// rtl/gcl_ram.sv - GCL entry storage, one write port and one registered read port
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data {mask, duration}
//   raddr  in   read index
//   rdata  out  read data, valid one cycle after raddr
module gcl_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // Write-first: a write and a read to the same index on the same edge
    // returns the new data, so a write issued alongside test start is seen
    // by the entry 0 fetch.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/gcl_sequencer.sv
// rtl/gcl_sequencer.sv - time-aware gate control list sequencer for 8 traffic-class queues
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_gcl_wr/waddr/wdata GCL table write port (accepted in IDLE only)
//   in_gcl_len            number of active entries, 1..2**ADDR_W
//   in_gcl_test_start     level: run list while high
//   in_gcl_queue_nempty   per-queue non-empty flags
//   out_gcl_gate          current gate-open mask (registered)
//   out_gcl_valid         gate & nempty (combinational)
//   out_gcl_idx           index of entry in force (registered)
//   out_gcl_cycle_start   pulse when entry 0 comes into force
//   out_gcl_err           pulse on rejected write or invalid len at start
module gcl_sequencer
    import gcl_sequencer_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DUR_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_gcl_wr,
    input  logic [ADDR_W-1:0]           in_gcl_waddr,
    input  logic [GCL_MASK_W+DUR_W-1:0] in_gcl_wdata,
    input  logic [ADDR_W:0]             in_gcl_len,
    input  logic                        in_gcl_test_start,
    input  logic [GCL_MASK_W-1:0]       in_gcl_queue_nempty,
    output logic [GCL_MASK_W-1:0]       out_gcl_gate,
    output logic [GCL_MASK_W-1:0]       out_gcl_valid,
    output logic [ADDR_W-1:0]           out_gcl_idx,
    output logic                        out_gcl_cycle_start,
    output logic                        out_gcl_err
);

    localparam int ENTRY_W = GCL_MASK_W + DUR_W;
    localparam int DEPTH   = 1 << ADDR_W;

    logic [1:0]            state;
    logic [DUR_W-1:0]      cnt;
    logic [ADDR_W:0]       len_q;
    logic [ADDR_W-1:0]     raddr;
    logic                  start_d;
    logic [ENTRY_W-1:0]    rdata;
    logic                  ram_we;
    logic [GCL_MASK_W-1:0] rd_mask;
    logic [DUR_W-1:0]      rd_dur;
    logic [DUR_W-1:0]      rd_cnt;
    logic                  len_ok;
    logic [ADDR_W-1:0]     idx_n;
    logic [ADDR_W-1:0]     idx_nn;
    logic [ADDR_W-1:0]     idx_first_n;

    // Wrap to entry 0 after the last active entry
    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] i,
                                              input logic [ADDR_W:0]   len);
        return ({1'b0, i} == (len - (ADDR_W+1)'(1))) ? '0 : i + ADDR_W'(1);
    endfunction

    assign ram_we = in_gcl_wr && (state == ST_IDLE);

    gcl_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_gcl_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (in_gcl_waddr),
        .wdata (in_gcl_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign rd_mask = rdata[DUR_W +: GCL_MASK_W];
    assign rd_dur  = rdata[GCL_DUR_LSB +: DUR_W];
    // Counter reload is eff(dur)-1 so the entry holds exactly eff(dur) cycles
    assign rd_cnt  = (rd_dur < DUR_W'(GCL_MIN_DUR)) ? DUR_W'(GCL_MIN_DUR - 1)
                                                    : rd_dur - DUR_W'(1);

    assign len_ok = (in_gcl_len != '0) && (in_gcl_len <= (ADDR_W+1)'(DEPTH));

    assign idx_n       = nxt(out_gcl_idx, len_q);
    assign idx_nn      = nxt(idx_n, len_q);
    assign idx_first_n = nxt('0, len_q);

    assign out_gcl_valid = out_gcl_gate & in_gcl_queue_nempty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            len_q               <= '0;
            raddr               <= '0;
            start_d             <= 1'b0;
            out_gcl_gate        <= '0;
            out_gcl_idx         <= '0;
            out_gcl_cycle_start <= 1'b0;
            out_gcl_err         <= 1'b0;
        end else begin
            start_d             <= in_gcl_test_start;
            out_gcl_cycle_start <= 1'b0;
            out_gcl_err         <= in_gcl_wr && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    // raddr parked at 0 so entry 0 is already being fetched
                    out_gcl_gate <= '0;
                    out_gcl_idx  <= '0;
                    cnt          <= '0;
                    raddr        <= '0;
                    if (in_gcl_test_start) begin
                        if (len_ok) begin
                            len_q <= in_gcl_len;
                            state <= ST_LOAD;
                        end else if (!start_d) begin
                            out_gcl_err <= 1'b1;
                        end
                    end
                end

                ST_LOAD, ST_RUN: begin
                    if (!in_gcl_test_start) begin
                        state        <= ST_IDLE;
                        out_gcl_gate <= '0;
                        out_gcl_idx  <= '0;
                        cnt          <= '0;
                        raddr        <= '0;
                    end else if (state == ST_LOAD) begin
                        out_gcl_gate        <= rd_mask;
                        out_gcl_idx         <= '0;
                        cnt                 <= rd_cnt;
                        out_gcl_cycle_start <= 1'b1;
                        raddr               <= idx_first_n;
                        state               <= ST_RUN;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DUR_W'(1);
                    end else begin
                        // rdata already holds entry idx_n; start fetching the one after
                        out_gcl_gate        <= rd_mask;
                        out_gcl_idx         <= idx_n;
                        cnt                 <= rd_cnt;
                        raddr               <= idx_nn;
                        out_gcl_cycle_start <= (idx_n == '0);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
